pc_gen: RTL
===========

# pc_gen

Front-end PC generator: holds the architectural fetch PC, issues fetch requests to the instruction cache over a valid/ready handshake, and forwards accepted PCs to the IF stage. It consumes the control block's outputs: `pause[0]`, exception flush, redirect target and interrupt-pending. It also consumes branch redirects from EX and the IDLE commit from MEM. Redirect priority is exception/ertn flush, then branch, then sequential PC+4.

## Interface
- `RESET_PC`, 32'h1C000000, first fetch address after reset.
- `clk` input 1, core clock.
- `rst_n` input 1, asynchronous, active-low reset.
- `pause_pc` input 1, `pause[0]` from control; holds the PC.
- `exception_flush` input 1, exception or ertn in MEM.
- `exception_in_pc` input 32, redirect target; EENTRY or ERA.
- `is_interrupt` input 1, enabled interrupt pending.
- `branch_flag` input 1, taken branch/jump resolved in EX.
- `branch_target` input 32, branch destination.
- `idle_en` input 1, IDLE instruction committing in MEM.
- `idle_pc` input 32, PC of that IDLE instruction.
- `inst_req_valid` output 1, fetch request valid.
- `inst_req_pc` output 32, fetch address.
- `inst_req_ready` input 1, icache accepts the request.
- `pc_o` output 32, PC handed to IF.
- `pc_valid_o` output 1, `pc_o` is a live (non-stale) fetch.
- `idle_o` output 1, core is parked in IDLE.

## Operation
- States: BOOT, RUN, HOLD, IDLE. `pc_q` is the current fetch PC. `pend_q`/`pend_pc_q` hold a latched redirect.
- **Reset values:** state BOOT, `pc_q`=RESET_PC, `pend_q`=0, `inst_req_valid`=0, `pc_o`=0, `pc_valid_o`=0, `idle_o`=0.
- **BOOT:** one cycle with no request, then go to RUN.
- **RUN:** `inst_req_valid`=1 and `inst_req_pc`=`pc_q`.
  - On acceptance (valid and ready), update `pc_q` by priority:
    - `exception_flush`, then `exception_in_pc`;
    - else `pend_q`, then `pend_pc_q`, and clear `pend_q`;
    - else `branch_flag`, then `branch_target`;
    - else `pause_pc`, then unchanged;
    - else `pc_q`+4, 32-bit wrap with no carry out.
  - On acceptance, register `pc_o`=`inst_req_pc`. Register `pc_valid_o`=1 unless a redirect (flush, pending or branch) applies in that same cycle, then 0.
  - Not accepted: go to HOLD.
- **HOLD:** request stays asserted, and `inst_req_pc` stays stable until ready. Flush or branch arriving in HOLD is written into `pend_q`/`pend_pc_q`; flush overwrites branch, and a later flush overwrites an earlier one. On ready, apply the pending target, emit `pc_valid_o`=0 for the stale PC, and go to RUN.
- **IDLE entry:** `idle_en` in any state except BOOT. If a request is outstanding, let it complete first; the IDLE transition then happens on that acceptance cycle.
  - Set `pc_q`=`idle_pc`+4, drop `inst_req_valid`, set `idle_o`=1.
- **IDLE exit:** on `exception_flush`, set `pc_q`=`exception_in_pc`. On `is_interrupt` alone, resume at `pc_q`. Both go to RUN the next cycle with `idle_o`=0.
- **Priorities and boundaries:**
  - `exception_flush` beats `idle_en` and `branch_flag` in the same cycle.
  - `pause_pc` never suppresses a redirect.
  - While `pause_pc`=1 with no redirect, `pc_o` and `pc_valid_o` hold.
- **Reset mid-operation:** async return to BOOT values; the pending redirect is discarded.

## Timing
- Redirect to first request at the new PC is 1 cycle in RUN, and 1 cycle after ready in HOLD.
- Accepted PC appears on `pc_o` the cycle after acceptance.
- Request interface outputs are combinational from registered state only; no combinational path from `inst_req_ready` to `inst_req_pc`.
- IDLE wake: interrupt asserted in cycle N gives `inst_req_valid`=1 in cycle N+1.

## Structure
- The shared defines file supplies `InstAddrWidth` and the reset PC constant, and gains a 2-bit state encoding for BOOT/RUN/HOLD/IDLE.
- Single module. Optional sub-module `pc_redirect_sel`: a purely combinational priority mux for flush/pending/branch/seq.

## Test plan
- **Reset release:** first request 0x1C000000 after one BOOT cycle; then 0x1C000004 and 0x1C000008 with ready tied high.
- **Branch in RUN:** `branch_flag`, target 0x1C000100, at acceptance of 0x1C000008. `pc_valid_o`=0 for 0x1C000008, next request 0x1C000100.
- **HOLD:**
  - Ready low for 3 cycles at 0x1C000010; `inst_req_pc` is stable.
  - Branch to 0x200, then flush to 0x1C008000, during the stall. After ready, next request 0x1C008000.
- **IDLE with interrupt:**
  - `idle_en` with `idle_pc`=0x1C000020 gives `idle_o`=1 and no requests.
  - `is_interrupt` pulse gives a request at 0x1C000024 the next cycle.
- **Pause vs flush:** `pause_pc` held high with flush to 0x1C00F000; the redirect is taken anyway.
- **Async reset mid-HOLD with pending redirect:** outputs at reset values immediately; first request is 0x1C000000.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared front-end fetch definitions: address width, reset PC, PC-gen state encoding.
package pc_gen_pkg;

    localparam int InstAddrWidth = 32;

    typedef logic [InstAddrWidth-1:0] addr_t;

    localparam addr_t ResetPc = 32'h1C00_0000;
    localparam addr_t PcStep  = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_IDLE = 2'd3
    } pc_state_e;

    // A latched redirect: target PC plus a flag saying it is live.
    typedef struct packed {
        logic  vld;
        addr_t pc;
    } redir_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request channel between the PC generator and the instruction cache.
interface pc_gen_if;
    import pc_gen_pkg::*;

    logic  inst_req_valid;
    addr_t inst_req_pc;
    logic  inst_req_ready;

    modport master (output inst_req_valid, output inst_req_pc, input inst_req_ready);
    modport slave  (input inst_req_valid, input inst_req_pc, output inst_req_ready);
endinterface

// File: rtl/pc_gen_redirect_sel.sv
// Next-fetch-PC priority mux: flush, latched redirect, branch, pause hold, sequential.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selected PC is committed.
module pc_redirect_sel
    import pc_gen_pkg::*;
(
    input  logic   i_flush,
    input  addr_t  i_flush_pc,
    input  redir_t i_pend,
    input  logic   i_branch,
    input  addr_t  i_branch_pc,
    input  logic   i_pause,
    input  addr_t  i_cur_pc,
    output addr_t  o_nxt_pc,
    output logic   o_redirect
);

    always_comb begin
        o_redirect = i_flush | i_pend.vld | i_branch;
        if (i_flush) begin
            o_nxt_pc = i_flush_pc;
        end else if (i_pend.vld) begin
            o_nxt_pc = i_pend.pc;
        end else if (i_branch) begin
            o_nxt_pc = i_branch_pc;
        end else if (i_pause) begin
            o_nxt_pc = i_cur_pc;
        end else begin
            o_nxt_pc = i_cur_pc + PcStep;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Front-end PC generator: owns the fetch PC, issues icache requests, forwards accepted PCs to IF.
// Latency: accepted PC on pc_o one cycle after acceptance; redirect reaches the request one cycle later.
// Backpressure: a stalled request holds its PC; redirects and IDLE arriving meanwhile are latched.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter addr_t RESET_PC = ResetPc
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   pause_pc,
    input  logic   exception_flush,
    input  addr_t  exception_in_pc,
    input  logic   is_interrupt,
    input  logic   branch_flag,
    input  addr_t  branch_target,
    input  logic   idle_en,
    input  addr_t  idle_pc,
    pc_gen_if.master req_if,
    output addr_t  pc_o,
    output logic   pc_valid_o,
    output logic   idle_o
);

    pc_state_e r_state;
    pc_state_e w_state_nxt;
    addr_t     r_pc;
    redir_t    r_pend;
    redir_t    r_idle_pend;

    logic      w_accept;
    logic      w_idle_hit;
    addr_t     w_idle_pc;
    addr_t     w_sel_pc;
    logic      w_redirect;
    logic      w_pause_hold;

    assign w_accept     = req_if.inst_req_valid & req_if.inst_req_ready;
    // IDLE is older than anything in EX but younger than the flushing MEM instruction.
    assign w_idle_hit   = ~exception_flush & (idle_en | r_idle_pend.vld);
    assign w_idle_pc    = r_idle_pend.vld ? r_idle_pend.pc : idle_pc;
    assign w_pause_hold = pause_pc & ~w_redirect;

    pc_redirect_sel u_sel (
        .i_flush     (exception_flush),
        .i_flush_pc  (exception_in_pc),
        .i_pend      (r_pend),
        .i_branch    (branch_flag),
        .i_branch_pc (branch_target),
        .i_pause     (pause_pc),
        .i_cur_pc    (r_pc),
        .o_nxt_pc    (w_sel_pc),
        .o_redirect  (w_redirect)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_BOOT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (w_accept) w_state_nxt = w_idle_hit ? ST_IDLE : ST_RUN;
                else          w_state_nxt = ST_HOLD;
            end
            ST_IDLE: begin
                if (exception_flush | is_interrupt) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        req_if.inst_req_valid = (r_state == ST_RUN) || (r_state == ST_HOLD);
        req_if.inst_req_pc    = r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_pend      <= '0;
            r_idle_pend <= '0;
            pc_o        <= '0;
            pc_valid_o  <= 1'b0;
            idle_o      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_HOLD: begin
                    if (w_accept) begin
                        r_pc        <= w_idle_hit ? (w_idle_pc + PcStep) : w_sel_pc;
                        r_pend      <= '0;
                        r_idle_pend <= '0;
                        idle_o      <= w_idle_hit;
                        if (!w_pause_hold) begin
                            pc_o       <= r_pc;
                            pc_valid_o <= ~w_redirect;
                        end
                    end else begin
                        // A flush supersedes anything latched; a branch only fills an empty slot.
                        if (exception_flush) begin
                            r_pend      <= '{vld: 1'b1, pc: exception_in_pc};
                            r_idle_pend <= '0;
                        end else begin
                            if (branch_flag && !r_pend.vld) begin
                                r_pend <= '{vld: 1'b1, pc: branch_target};
                            end
                            if (idle_en && !r_idle_pend.vld) begin
                                r_idle_pend <= '{vld: 1'b1, pc: idle_pc};
                            end
                        end
                        if (!w_pause_hold) pc_valid_o <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    pc_valid_o <= 1'b0;
                    if (exception_flush) r_pc <= exception_in_pc;
                    if (exception_flush | is_interrupt) idle_o <= 1'b0;
                end
                default: pc_valid_o <= 1'b0;
            endcase
        end
    end

endmodule
